// File: rtl/flatten_fc_ibuf_ctrl_pkg.sv
// Shared types and sizing helpers for the flatten/FC input buffer and its sequencer.
// Keeping the sizing here means the buffer and this controller derive identical address ranges.
package flatten_fc_ibuf_ctrl_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } ibuf_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int calc_v_tiles(input int ch, input int img, input int xbar);
        return ceil_div(ch * img, xbar);
    endfunction

    function automatic int calc_num_addr(input int ch, input int img, input int xbar, input int bus_w);
        return ceil_div(ch * img, bus_w * calc_v_tiles(ch, img, xbar));
    endfunction

    // A one-entry range still needs a one-bit select.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/flatten_fc_ibuf_ctrl_if.sv
// Upstream pixel handshake, ibuf select lines and CIM beat handshake of the input-buffer sequencer.
// Handshakes: a transfer happens in a cycle where valid and ready are both 1; the sender holds its data while ready is 0.
interface flatten_fc_ibuf_ctrl_if #(
    parameter int INPUT_CHANNELS = 2,
    parameter int ADDR_WIDTH     = 1,
    parameter int COUNT_WIDTH    = 3
);
    logic [INPUT_CHANNELS-1:0] i_valid;
    logic [INPUT_CHANNELS-1:0] o_ready;
    logic [INPUT_CHANNELS-1:0] o_write_enable;
    logic [ADDR_WIDTH-1:0]     o_ibuf_addr;
    logic [COUNT_WIDTH-1:0]    o_count;
    logic                      o_cim_valid;
    logic                      i_cim_ready;
    logic                      o_last;
    logic                      o_frame_done;

    modport slave (
        input  i_valid, i_cim_ready,
        output o_ready, o_write_enable, o_ibuf_addr, o_count, o_cim_valid, o_last, o_frame_done
    );

    modport master (
        output i_valid, i_cim_ready,
        input  o_ready, o_write_enable, o_ibuf_addr, o_count, o_cim_valid, o_last, o_frame_done
    );
endinterface

// File: rtl/flatten_fc_ibuf_ctrl_beat_counter.sv
// Two-level readout counter: bus address inner, bit-plane count outer, both wrapping to zero.
// o_last flags the final (count, addr) pair of a frame.
module flatten_fc_ibuf_ctrl_beat_counter #(
    parameter int NUM_ADDR    = 3,
    parameter int DATA_SIZE   = 8,
    parameter int ADDR_WIDTH  = 2,
    parameter int COUNT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic                   i_clr,
    output logic [ADDR_WIDTH-1:0]  o_addr,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_last
);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_MAX  = ADDR_WIDTH'(NUM_ADDR - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(DATA_SIZE - 1);

    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   w_addr_wrap;
    logic                   w_count_wrap;

    assign w_addr_wrap  = (r_addr == ADDR_MAX);
    assign w_count_wrap = (r_count == COUNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_addr  <= '0;
            r_count <= '0;
        end else if (i_en) begin
            if (w_addr_wrap) begin
                r_addr  <= '0;
                r_count <= w_count_wrap ? '0 : r_count + COUNT_WIDTH'(1);
            end else begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
        end
    end

    assign o_addr  = r_addr;
    assign o_count = r_count;
    assign o_last  = w_addr_wrap & w_count_wrap;
endmodule

// File: rtl/flatten_fc_ibuf_ctrl.sv
// Input-buffer sequencer: admits one frame of pixels per channel, then streams every
// (bit-plane, address) beat of the buffer to the FC CIM tiles before accepting the next frame.
module flatten_fc_ibuf_ctrl
    import flatten_fc_ibuf_ctrl_pkg::*;
#(
    parameter int DATA_SIZE      = 8,
    parameter int IMG_SIZE       = 784,
    parameter int INPUT_CHANNELS = 2,
    parameter int XBAR_SIZE      = 128,
    parameter int BUS_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    flatten_fc_ibuf_ctrl_if.slave bus,
    output ibuf_state_t           o_dbg_state
);
    localparam int NUM_ADDR    = calc_num_addr(INPUT_CHANNELS, IMG_SIZE, XBAR_SIZE, BUS_WIDTH);
    localparam int ADDR_WIDTH  = width_of(NUM_ADDR);
    localparam int COUNT_WIDTH = width_of(DATA_SIZE);
    localparam int PIX_WIDTH   = $clog2(IMG_SIZE + 1);
    localparam logic [PIX_WIDTH-1:0] PIX_FULL = PIX_WIDTH'(IMG_SIZE);

    ibuf_state_t               r_state;
    ibuf_state_t               w_next_state;
    logic [PIX_WIDTH-1:0]      r_pix_cnt [INPUT_CHANNELS];
    logic [INPUT_CHANNELS-1:0] w_ready;
    logic [INPUT_CHANNELS-1:0] w_we;
    logic                      w_all_full_next;
    logic                      w_cim_valid;
    logic                      w_frame_done;
    logic                      w_last;
    logic                      w_beat_en;
    logic                      w_beat_clr;
    logic [ADDR_WIDTH-1:0]     w_addr;
    logic [COUNT_WIDTH-1:0]    w_count;

    // Full-ness is judged on the counts after this cycle's writes, so the
    // state flips on the same edge that lands the last pixel in the buffer.
    always_comb begin
        w_ready         = '0;
        w_we            = '0;
        w_all_full_next = 1'b1;
        for (int c = 0; c < INPUT_CHANNELS; c++) begin
            w_ready[c] = (r_state == FILL) && (r_pix_cnt[c] != PIX_FULL);
            w_we[c]    = bus.i_valid[c] & w_ready[c];
            if ((r_pix_cnt[c] + PIX_WIDTH'(w_we[c])) != PIX_FULL) begin
                w_all_full_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < INPUT_CHANNELS; c++) r_pix_cnt[c] <= '0;
        end else if (r_state == DONE) begin
            for (int c = 0; c < INPUT_CHANNELS; c++) r_pix_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < INPUT_CHANNELS; c++) begin
                if (w_we[c]) r_pix_cnt[c] <= r_pix_cnt[c] + PIX_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FILL;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = FILL;
        case (r_state)
            FILL:    w_next_state = w_all_full_next ? READ : FILL;
            READ:    w_next_state = (bus.i_cim_ready && w_last) ? DONE : READ;
            DONE:    w_next_state = FILL;
            default: w_next_state = FILL;
        endcase
    end

    always_comb begin
        w_cim_valid  = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            READ:    w_cim_valid  = 1'b1;
            DONE:    w_frame_done = 1'b1;
            default: ;
        endcase
    end

    assign w_beat_en  = w_cim_valid & bus.i_cim_ready;
    assign w_beat_clr = w_frame_done;

    flatten_fc_ibuf_ctrl_beat_counter #(
        .NUM_ADDR    (NUM_ADDR),
        .DATA_SIZE   (DATA_SIZE),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_beat_counter (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_beat_en),
        .i_clr   (w_beat_clr),
        .o_addr  (w_addr),
        .o_count (w_count),
        .o_last  (w_last)
    );

    assign bus.o_ready        = w_ready;
    assign bus.o_write_enable = w_we;
    assign bus.o_ibuf_addr    = w_addr;
    assign bus.o_count        = w_count;
    assign bus.o_cim_valid    = w_cim_valid;
    assign bus.o_last         = w_cim_valid & w_last;
    assign bus.o_frame_done   = w_frame_done;
    assign o_dbg_state        = r_state;
endmodule
